reg_write_arb: RTL and testbench

REG_WRITE_ARB -- requirements
Module: reg_write_arb

---
 rtl/reg_write_arb.sv | 104 ++++++++++
 tb/tb_reg_write_arb.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arb.sv
// Arbitrates the single GRF write port between the W stage and a 2-entry long-latency queue.
// Grant is combinational; queued writes land the cycle after enqueue at earliest; mdReady drops when full.
module reg_write_arb #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wbEn,
    input  logic [4:0]  wbAddr,
    input  logic [31:0] wbData,
    input  logic        mdValid,
    input  logic [4:0]  mdAddr,
    input  logic [31:0] mdData,
    output logic        mdReady,
    output logic        grfWE,
    output logic [4:0]  grfAddr,
    output logic [31:0] grfData,
    output logic        stallReq,
    output logic [31:0] pendMask
);

    logic [4:0]  q_addr0, q_addr1;
    logic [31:0] q_data0, q_data1;
    logic [1:0]  count;
    logic [2:0]  waitCnt;

    logic        has_head;
    logic        wb_take;
    logic        grant_fifo;
    logic        supersede;
    logic        pop;
    logic        enq;
    logic [1:0]  base;
    logic [1:0]  count_nxt;

    always_comb begin
        has_head   = (count != 2'd0);
        mdReady    = (count < 2'd2);
        // A frozen W stage re-presents its write later, so it never competes here.
        wb_take    = wbEn && !stallReq && (wbAddr != 5'd0);
        grant_fifo = has_head && !wb_take;
        supersede  = wb_take && has_head && (q_addr0 == wbAddr);
        pop        = grant_fifo || supersede;
        enq        = mdValid && mdReady && (mdAddr != 5'd0);
        base       = count - {1'b0, pop};
        count_nxt  = base + {1'b0, enq};

        grfWE   = 1'b0;
        grfAddr = 5'd0;
        grfData = 32'd0;
        if (wb_take) begin
            grfWE   = 1'b1;
            grfAddr = wbAddr;
            grfData = wbData;
        end else if (grant_fifo) begin
            grfWE   = 1'b1;
            grfAddr = q_addr0;
            grfData = q_data0;
        end

        pendMask = 32'd0;
        if (count >= 2'd1) pendMask = pendMask | (32'd1 << q_addr0);
        if (count == 2'd2) pendMask = pendMask | (32'd1 << q_addr1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= 2'd0;
            waitCnt  <= 3'd0;
            stallReq <= 1'b0;
            q_addr0  <= 5'd0;
            q_addr1  <= 5'd0;
            q_data0  <= 32'd0;
            q_data1  <= 32'd0;
        end else begin
            if (pop) begin
                q_addr0 <= q_addr1;
                q_data0 <= q_data1;
            end
            // New entry goes to the first free slot after any pop; later NBA wins over the shift.
            if (enq) begin
                if (base == 2'd0) begin
                    q_addr0 <= mdAddr;
                    q_data0 <= mdData;
                end else begin
                    q_addr1 <= mdAddr;
                    q_data1 <= mdData;
                end
            end
            count <= count_nxt;

            if (!has_head || pop)
                waitCnt <= 3'd0;
            else if (waitCnt != 3'd7)
                waitCnt <= waitCnt + 3'd1;

            if (grant_fifo)
                stallReq <= 1'b0;
            else if (has_head && !pop && (waitCnt == 3'(STARVE_LIMIT)))
                stallReq <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_write_arb.sv
// Directed bench for reg_write_arb: vector table plus hand sequences for starvation and reset.
module tb_reg_write_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic        wbEn;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        mdValid;
    logic [4:0]  mdAddr;
    logic [31:0] mdData;
    logic        mdReady;
    logic        grfWE;
    logic [4:0]  grfAddr;
    logic [31:0] grfData;
    logic        stallReq;
    logic [31:0] pendMask;

    int checks   = 0;
    int failures = 0;

    reg_write_arb #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .reset(reset),
        .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData),
        .mdValid(mdValid), .mdAddr(mdAddr), .mdData(mdData),
        .mdReady(mdReady),
        .grfWE(grfWE), .grfAddr(grfAddr), .grfData(grfData),
        .stallReq(stallReq), .pendMask(pendMask)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        mv;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        e_rdy;
        logic        e_we;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_stall;
        logic [31:0] e_pend;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        reset   = r;
        wbEn    = we;
        wbAddr  = wa;
        wbData  = wd;
        mdValid = mv;
        mdAddr  = ma;
        mdData  = md;
    endtask

    task automatic expect_out(input string nm, input logic rdy, input logic we, input logic [4:0] a,
                              input logic [31:0] d, input logic st, input logic [31:0] pm);
        chk({nm, ".mdReady"},  {31'd0, mdReady},  {31'd0, rdy});
        chk({nm, ".grfWE"},    {31'd0, grfWE},    {31'd0, we});
        chk({nm, ".grfAddr"},  {27'd0, grfAddr},  {27'd0, a});
        chk({nm, ".grfData"},  grfData,           d);
        chk({nm, ".stallReq"}, {31'd0, stallReq}, {31'd0, st});
        chk({nm, ".pendMask"}, pendMask,          pm);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // idle / single queued write
        vecs[0]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd5, 32'hAAAA0001, 1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd5,  32'hAAAA0001, 1'b0, 32'h20};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        // pipeline beats queue, queue drains on first free cycle
        vecs[4]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd8, 32'h88,       1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        vecs[5]  = '{1'b1, 5'd9,  32'h1234, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd9,  32'h1234,     1'b0, 32'h100};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd8,  32'h88,       1'b0, 32'h100};
        vecs[7]  = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        // supersede, then $0 handshake
        vecs[8]  = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd7, 32'h77,       1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        vecs[9]  = '{1'b1, 5'd7,  32'h7777, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd7,  32'h7777,     1'b0, 32'h80};
        vecs[10] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd0, 32'hDEAD,     1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        vecs[12] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};
        // fill while pipeline busy; third request waits for a pop
        vecs[13] = '{1'b1, 5'd20, 32'h2020, 1'b1, 5'd3, 32'h33,       1'b1, 1'b1, 5'd20, 32'h2020,     1'b0, 32'h0};
        vecs[14] = '{1'b1, 5'd20, 32'h2020, 1'b1, 5'd4, 32'h44,       1'b1, 1'b1, 5'd20, 32'h2020,     1'b0, 32'h8};
        vecs[15] = '{1'b1, 5'd20, 32'h2020, 1'b1, 5'd6, 32'h66,       1'b0, 1'b1, 5'd20, 32'h2020,     1'b0, 32'h18};
        vecs[16] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd6, 32'h66,       1'b0, 1'b1, 5'd3,  32'h33,       1'b0, 32'h18};
        vecs[17] = '{1'b0, 5'd0,  32'h0,    1'b1, 5'd6, 32'h66,       1'b1, 1'b1, 5'd4,  32'h44,       1'b0, 32'h10};
        vecs[18] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 5'd6,  32'h66,       1'b0, 32'h40};
        vecs[19] = '{1'b0, 5'd0,  32'h0,    1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 5'd0,  32'h0,        1'b0, 32'h0};

        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        next_cycle();
        next_cycle();
        @(negedge clk);
        expect_out("reset", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);

        for (int i = 0; i < 20; i++) begin
            next_cycle();
            drive(1'b0, vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].mv, vecs[i].ma, vecs[i].md);
            @(negedge clk);
            expect_out($sformatf("row%0d", i), vecs[i].e_rdy, vecs[i].e_we, vecs[i].e_addr,
                       vecs[i].e_data, vecs[i].e_stall, vecs[i].e_pend);
        end

        // Starvation: $10 queued behind a W stage writing $11 every cycle.
        next_cycle();
        drive(1'b0, 1'b1, 5'd11, 32'h1111, 1'b1, 5'd10, 32'h1010);
        @(negedge clk);
        expect_out("starve_enq", 1'b1, 1'b1, 5'd11, 32'h1111, 1'b0, 32'h0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            drive(1'b0, 1'b1, 5'd11, 32'h1111, 1'b0, 5'd0, 32'h0);
            @(negedge clk);
            expect_out($sformatf("starve_deny%0d", k), 1'b1, 1'b1, 5'd11, 32'h1111, 1'b0, 32'h400);
        end
        next_cycle();
        drive(1'b0, 1'b1, 5'd11, 32'h1111, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        expect_out("starve_force", 1'b1, 1'b1, 5'd10, 32'h1010, 1'b1, 32'h400);
        next_cycle();
        drive(1'b0, 1'b1, 5'd11, 32'h1111, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        expect_out("starve_release", 1'b1, 1'b1, 5'd11, 32'h1111, 1'b0, 32'h0);

        // Reset mid-operation: full queue with stall raised.
        next_cycle();
        drive(1'b0, 1'b1, 5'd11, 32'h1111, 1'b1, 5'd12, 32'h1212);
        @(negedge clk);
        expect_out("mid_enq0", 1'b1, 1'b1, 5'd11, 32'h1111, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b1, 5'd11, 32'h1111, 1'b1, 5'd13, 32'h1313);
        @(negedge clk);
        expect_out("mid_enq1", 1'b1, 1'b1, 5'd11, 32'h1111, 1'b0, 32'h1000);
        for (int k = 2; k <= 4; k++) begin
            next_cycle();
            drive(1'b0, 1'b1, 5'd11, 32'h1111, 1'b0, 5'd0, 32'h0);
            @(negedge clk);
            expect_out($sformatf("mid_full%0d", k), 1'b0, 1'b1, 5'd11, 32'h1111, 1'b0, 32'h3000);
        end
        next_cycle();
        drive(1'b1, 1'b1, 5'd11, 32'h1111, 1'b1, 5'd14, 32'h1414);
        @(negedge clk);
        expect_out("mid_stalled", 1'b0, 1'b1, 5'd12, 32'h1212, 1'b1, 32'h3000);
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        expect_out("mid_after_reset", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        @(negedge clk);
        expect_out("mid_after_reset2", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);

        // A handshake offered during reset must be dropped.
        next_cycle();
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd15, 32'h1515);
        @(negedge clk);
        expect_out("rst_hs", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);
        next_cycle();
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        expect_out("rst_hs_dropped", 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
